// File: rtl/nios_dbg_cmd_sysclk_pkg.sv
// nios_dbg_pkg: shared constants and helpers for the debug command path.
//   DEF_*            default parameter values for nios_dbg_cmd_sysclk
//   MIN_SYNC_STAGES  smallest synchroniser depth that is metastability-safe
//   even_parity_err  returns 1 when an even-parity-protected vector is bad
package nios_dbg_pkg;

    localparam int unsigned DEF_IR_WIDTH    = 2;
    localparam int unsigned DEF_DATA_WIDTH  = 38;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned MIN_SYNC_STAGES = 2;

    // Widest {data, parity} vector the helper accepts; callers zero-extend.
    localparam int unsigned PAR_MAX_WIDTH   = 256;

    // Data plus its even-parity bit must XOR to zero.
    function automatic logic even_parity_err(input logic [PAR_MAX_WIDTH-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/nios_dbg_cmd_sysclk_if.sv
// nios_dbg_cmd_sysclk_if: command channel from the debug FIFO to its consumer.
//   cmd_valid    head entry present
//   cmd_ready    consumer accepts the head
//   cmd_ir       head instruction
//   cmd_data     head data word
//   take_action  one-hot action strobe, bit cmd_ir, on handshake
// modport master: FIFO side; modport slave: consumer side.
interface nios_dbg_cmd_sysclk_if
    import nios_dbg_pkg::*;
#(
    parameter int unsigned IR_WIDTH   = DEF_IR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [IR_WIDTH-1:0]         cmd_ir;
    logic [DATA_WIDTH-1:0]       cmd_data;
    logic [(1 << IR_WIDTH)-1:0]  take_action;

    modport master (
        output cmd_valid,
        output cmd_ir,
        output cmd_data,
        output take_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ir,
        input  cmd_data,
        input  take_action,
        output cmd_ready
    );

endinterface

// File: rtl/nios_dbg_cmd_sysclk_sync_edge.sv
// nios_dbg_sync_edge: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector; emits one clk-cycle pulse per rising edge of async_in.
//   clk       system clock
//   reset_n   synchronous active-low reset (clears all flops)
//   async_in  level from another clock domain
//   rise      one-cycle pulse after the synchronised level goes 0->1
module nios_dbg_sync_edge
    import nios_dbg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Cleared edge register means a level already high at reset release
    // is seen as one fresh edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nios_dbg_cmd_sysclk.sv
// nios_dbg_cmd_sysclk: moves JTAG update-DR captures {ir_in, sr} into the
// system clock domain and queues them in a DEPTH-entry command FIFO.
//   clk, reset_n  system clock, synchronous active-low reset
//   vs_udr        update-DR level (async); each rising edge pushes {ir_in, sr}
//   vs_uir        update-IR level (async); each rising edge pulses ir_update
//   ir_in, sr     captured instruction/data, stable while vs_udr high
//   cmd_if        command channel (valid/ready, head ir/data, take_action)
//   ir_update     one-cycle pulse per synchronised vs_uir rising edge
//   cmd_count     FIFO occupancy, 0..DEPTH
//   ovf           sticky: a push was dropped because the FIFO was full
//   ovf_clr       clears ovf (a same-cycle overflow wins)
// Optional macro NIOS_DBG_CMD_PARITY_EN adds:
//   sr_par        even parity over sr
//   par_err       sticky: a push was dropped for bad parity (cleared by ovf_clr)
module nios_dbg_cmd_sysclk
    import nios_dbg_pkg::*;
#(
    parameter int unsigned IR_WIDTH    = DEF_IR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        vs_udr,
    input  logic                        vs_uir,
    input  logic [IR_WIDTH-1:0]         ir_in,
    input  logic [DATA_WIDTH-1:0]       sr,
`ifdef NIOS_DBG_CMD_PARITY_EN
    input  logic                        sr_par,
    output logic                        par_err,
`endif
    nios_dbg_cmd_sysclk_if.master       cmd_if,
    output logic                        ir_update,
    output logic [$clog2(DEPTH):0]      cmd_count,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ACT_W = 1 << IR_WIDTH;

    logic                  udr_pulse;
    logic                  push_req;
    logic                  push_en;
    logic                  pop;
    logic                  full;
    logic                  drop;

    logic [IR_WIDTH-1:0]   ir_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  ovf_q;
    logic [ACT_W-1:0]      action;

    nios_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (udr_pulse)
    );

    nios_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (ir_update)
    );

`ifdef NIOS_DBG_CMD_PARITY_EN
    logic par_bad;
    logic par_err_q;

    assign par_bad  = even_parity_err(PAR_MAX_WIDTH'({sr, sr_par}));
    assign push_req = udr_pulse & ~par_bad;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
        end else if (udr_pulse && par_bad) begin
            par_err_q <= 1'b1;
        end else if (ovf_clr) begin
            par_err_q <= 1'b0;
        end
    end

    assign par_err = par_err_q;
`else
    assign push_req = udr_pulse;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        pop     = (count_q != '0) && cmd_if.cmd_ready;
        push_en = push_req && (!full || pop);
        drop    = push_req && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (reset_n && push_en) begin
            ir_mem[wr_ptr_q]   <= ir_in;
            data_mem[wr_ptr_q] <= sr;
        end
    end

    always_comb begin
        action = '0;
        if (pop) begin
            action[ir_mem[rd_ptr_q]] = 1'b1;
        end
    end

    assign cmd_if.cmd_valid   = (count_q != '0);
    assign cmd_if.cmd_ir      = ir_mem[rd_ptr_q];
    assign cmd_if.cmd_data    = data_mem[rd_ptr_q];
    assign cmd_if.take_action = action;
    assign cmd_count          = count_q;
    assign ovf                = ovf_q;

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk.sv
// Self-checking bench for nios_dbg_cmd_sysclk (default parameters).
module tb_nios_dbg_cmd_sysclk;

    localparam int unsigned IRW   = 2;
    localparam int unsigned DW    = 38;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           vs_udr;
    logic           vs_uir;
    logic           ovf_clr;
    logic [IRW-1:0] ir_in;
    logic [DW-1:0]  sr;
    logic           ir_update;
    logic           ovf;
    logic [2:0]     cmd_count;
`ifdef NIOS_DBG_CMD_PARITY_EN
    logic           sr_par;
    logic           par_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    nios_dbg_cmd_sysclk_if #(.IR_WIDTH(IRW), .DATA_WIDTH(DW)) cmd_if ();

    nios_dbg_cmd_sysclk #(
        .IR_WIDTH    (IRW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vs_udr    (vs_udr),
        .vs_uir    (vs_uir),
        .ir_in     (ir_in),
        .sr        (sr),
`ifdef NIOS_DBG_CMD_PARITY_EN
        .sr_par    (sr_par),
        .par_err   (par_err),
`endif
        .cmd_if    (cmd_if),
        .ir_update (ir_update),
        .cmd_count (cmd_count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [DW-1:0]  data;
        logic [3:0]     exp_act;
    } vec_t;

    vec_t           vecs [5];
    logic [IRW-1:0] q_ir   [5];
    logic [DW-1:0]  q_data [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [IRW-1:0] ir, input logic [DW-1:0] d);
        ir_in = ir;
        sr    = d;
`ifdef NIOS_DBG_CMD_PARITY_EN
        sr_par = ^d;
`endif
    endtask

    // One vs_udr pulse; returns once the write edge has passed.
    task automatic push(input logic [IRW-1:0] ir, input logic [DW-1:0] d);
        set_cmd(ir, d);
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_check(input string name, input logic [IRW-1:0] ir, input logic [DW-1:0] d);
        logic [3:0] exp_act;
        exp_act = 4'b0001 << ir;
        check({name, " valid"}, 64'(cmd_if.cmd_valid), 64'(1));
        check({name, " ir"},    64'(cmd_if.cmd_ir),    64'(ir));
        check({name, " data"},  64'(cmd_if.cmd_data),  64'(d));
        cmd_if.cmd_ready = 1'b1;
        #1;
        check({name, " action"}, 64'(cmd_if.take_action), 64'(exp_act));
        tick();
        cmd_if.cmd_ready = 1'b0;
        #1;
        check({name, " action after"}, 64'(cmd_if.take_action), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{ir: 2'b01, data: 38'h15_5555_5555, exp_act: 4'b0010};
        vecs[1] = '{ir: 2'b00, data: 38'h00_0000_0000, exp_act: 4'b0001};
        vecs[2] = '{ir: 2'b10, data: 38'h3F_FFFF_FFFF, exp_act: 4'b0100};
        vecs[3] = '{ir: 2'b11, data: 38'h20_0000_0001, exp_act: 4'b1000};
        vecs[4] = '{ir: 2'b10, data: 38'h0A_BCDE_F012, exp_act: 4'b0100};

        q_ir[0] = 2'b00; q_data[0] = 38'h01_0000_0001;
        q_ir[1] = 2'b01; q_data[1] = 38'h02_2222_2222;
        q_ir[2] = 2'b10; q_data[2] = 38'h0A_BCDE_F012;
        q_ir[3] = 2'b11; q_data[3] = 38'h3F_0000_FFFF;
        q_ir[4] = 2'b01; q_data[4] = 38'h12_3456_789A;

        reset_n = 1'b0;
        vs_udr  = 1'b0;
        vs_uir  = 1'b0;
        ovf_clr = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        set_cmd('0, '0);
        tick();
        tick();
        tick();
        check("reset valid",     64'(cmd_if.cmd_valid),   64'(0));
        check("reset count",     64'(cmd_count),          64'(0));
        check("reset ovf",       64'(ovf),                64'(0));
        check("reset action",    64'(cmd_if.take_action), 64'(0));
        check("reset ir_update", 64'(ir_update),          64'(0));
        reset_n = 1'b1;
        tick();

        // Single-command vectors: latency, head contents, action decode.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("v%0d empty", i), 64'(cmd_count), 64'(0));
            set_cmd(vecs[i].ir, vecs[i].data);
            vs_udr = 1'b1;
            tick();
            vs_udr = 1'b0;
            check($sformatf("v%0d valid edge1", i), 64'(cmd_if.cmd_valid), 64'(0));
            tick();
            check($sformatf("v%0d valid edge2", i), 64'(cmd_if.cmd_valid), 64'(0));
            tick();
            check($sformatf("v%0d count", i),  64'(cmd_count),          64'(1));
            check($sformatf("v%0d idle action", i), 64'(cmd_if.take_action), 64'(0));
            check($sformatf("v%0d exp action", i), 64'(vecs[i].exp_act), 64'(4'b0001 << vecs[i].ir));
            pop_check($sformatf("v%0d", i), vecs[i].ir, vecs[i].data);
            check($sformatf("v%0d drained", i), 64'(cmd_if.cmd_valid), 64'(0));
        end

        // Ready without valid does nothing.
        cmd_if.cmd_ready = 1'b1;
        #1;
        check("idle ready action", 64'(cmd_if.take_action), 64'(0));
        tick();
        check("idle ready count", 64'(cmd_count), 64'(0));
        cmd_if.cmd_ready = 1'b0;

        // Overflow: five pushes into four entries.
        for (int i = 0; i < 4; i++) push(q_ir[i], q_data[i]);
        check("fill count", 64'(cmd_count), 64'(4));
        check("fill ovf",   64'(ovf),       64'(0));
        check("fill head",  64'(cmd_if.cmd_data), 64'(q_data[0]));
        push(q_ir[4], q_data[4]);
        check("ovf count", 64'(cmd_count), 64'(4));
        check("ovf set",   64'(ovf),       64'(1));
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf pop%0d", i), q_ir[i], q_data[i]);
        check("ovf drained", 64'(cmd_count), 64'(0));
        check("ovf sticky",  64'(ovf),       64'(1));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf cleared", 64'(ovf), 64'(0));

        // Full FIFO with push and pop in the same cycle.
        for (int i = 0; i < 4; i++) push(q_ir[i], q_data[i]);
        set_cmd(2'b10, 38'h2A_AAAA_AAAA);
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        cmd_if.cmd_ready = 1'b1;
        #1;
        check("fullpop action", 64'(cmd_if.take_action), 64'(4'b0001));
        tick();
        cmd_if.cmd_ready = 1'b0;
        check("fullpop count", 64'(cmd_count), 64'(4));
        check("fullpop ovf",   64'(ovf),       64'(0));
        for (int i = 1; i < 4; i++) pop_check($sformatf("fullpop pop%0d", i), q_ir[i], q_data[i]);
        pop_check("fullpop tail", 2'b10, 38'h2A_AAAA_AAAA);
        check("fullpop drained", 64'(cmd_count), 64'(0));

        // Overflow coinciding with ovf_clr: set wins.
        for (int i = 0; i < 4; i++) push(q_ir[i], q_data[i]);
        set_cmd(2'b11, 38'h33_3333_3333);
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("setwins ovf",   64'(ovf),       64'(1));
        check("setwins count", 64'(cmd_count), 64'(4));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("setwins clear", 64'(ovf), 64'(0));
        for (int i = 0; i < 4; i++) pop_check($sformatf("setwins pop%0d", i), q_ir[i], q_data[i]);

        // Reset with three queued, vs_udr held high across release.
        for (int i = 0; i < 3; i++) push(q_ir[i], q_data[i]);
        check("rst queued", 64'(cmd_count), 64'(3));
        set_cmd(2'b11, 38'h3C_3C3C_3C3C);
        cmd_if.cmd_ready = 1'b1;
        vs_udr  = 1'b1;
        reset_n = 1'b0;
        tick();
        check("rst valid",  64'(cmd_if.cmd_valid),   64'(0));
        check("rst count",  64'(cmd_count),          64'(0));
        check("rst action", 64'(cmd_if.take_action), 64'(0));
        tick();
        cmd_if.cmd_ready = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        check("rst rel early", 64'(cmd_count), 64'(0));
        tick();
        check("rst rel push", 64'(cmd_count), 64'(1));
        for (int i = 0; i < 5; i++) tick();
        check("rst rel single", 64'(cmd_count), 64'(1));
        vs_udr = 1'b0;
        pop_check("rst rel pop", 2'b11, 38'h3C_3C3C_3C3C);

        // vs_uir edge: one ir_update pulse, FIFO untouched.
        push(2'b01, 38'h11_1111_1111);
        vs_uir = 1'b1;
        tick();
        check("uir edge1", 64'(ir_update), 64'(0));
        tick();
        check("uir pulse", 64'(ir_update), 64'(1));
        tick();
        check("uir after", 64'(ir_update), 64'(0));
        tick();
        check("uir held",  64'(ir_update), 64'(0));
        vs_uir = 1'b0;
        check("uir count", 64'(cmd_count), 64'(1));
        check("uir data",  64'(cmd_if.cmd_data), 64'(38'h11_1111_1111));
        pop_check("uir pop", 2'b01, 38'h11_1111_1111);

`ifdef NIOS_DBG_CMD_PARITY_EN
        // Bad parity drops the push and flags par_err.
        ir_in  = 2'b00;
        sr     = 38'h1;
        sr_par = 1'b0;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        tick();
        check("par bad count", 64'(cmd_count), 64'(0));
        check("par bad err",   64'(par_err),   64'(1));
        check("par bad ovf",   64'(ovf),       64'(0));
        sr_par = 1'b1;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        tick();
        check("par good count", 64'(cmd_count), 64'(1));
        pop_check("par good pop", 2'b00, 38'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("par err clear", 64'(par_err), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
